// File: rtl/l2_cache_write_pkg.sv
// Shared L2 constants, PCI op codes, write-back entry layout and the byte-merge helper.
package l2_cache_write_pkg;
  localparam int L2_SET_INDEX_WIDTH  = 5;
  localparam int L2_WAY_INDEX_WIDTH  = 2;
  localparam int L2_TAG_WIDTH        = 26 - L2_SET_INDEX_WIDTH;
  localparam int L2_CACHE_ADDR_WIDTH = L2_WAY_INDEX_WIDTH + L2_SET_INDEX_WIDTH;

  localparam logic [2:0] PCI_LOAD       = 3'd0;
  localparam logic [2:0] PCI_STORE      = 3'd1;
  localparam logic [2:0] PCI_FLUSH      = 3'd2;
  localparam logic [2:0] PCI_INVALIDATE = 3'd3;
  localparam logic [2:0] PCI_LOAD_SYNC  = 3'd4;
  localparam logic [2:0] PCI_STORE_SYNC = 3'd5;

  typedef struct packed {
    logic [25:0]  address;
    logic [511:0] data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  function automatic logic [511:0] merge_line(input logic [511:0] src,
                                              input logic [511:0] data,
                                              input logic [63:0]  mask);
    logic [511:0] m;
    m = src;
    for (int i = 0; i < 64; i++)
      if (mask[i]) m[8*i +: 8] = data[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/l2_writeback_fifo.sv
// Write-back queue for dirty victim lines; head is always presented on head_data.
module l2_writeback_fifo
  import l2_cache_write_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = WB_ENTRY_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_HI   = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           head_ptr, tail_ptr;
  logic [PW:0]             cnt;
  logic                    full;

  assign empty       = (cnt == '0);
  assign full        = (cnt == CNT_FULL);
  assign almost_full = (cnt >= CNT_HI);
  assign head_data   = mem[head_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem      <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      if (pop) head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // upstream stalls one entry early, so a push into a full queue is a protocol bug
  always @(posedge clk)
    if (reset_n) assert (!(push && full && !pop));
endmodule

// File: rtl/l2_cache_write.sv
// L2 write stage: merges store data into the cached or filled line, writes the SRAM and queues dirty victims.
module l2_cache_write
  import l2_cache_write_pkg::*;
#(
  parameter int WB_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           stall_pipeline,
  input  logic                           rd_pci_valid,
  input  logic [1:0]                     rd_pci_unit,
  input  logic [1:0]                     rd_pci_strand,
  input  logic [2:0]                     rd_pci_op,
  input  logic [1:0]                     rd_pci_way,
  input  logic [25:0]                    rd_pci_address,
  input  logic [511:0]                   rd_pci_data,
  input  logic [63:0]                    rd_pci_mask,
  input  logic                           rd_has_sm_data,
  input  logic [511:0]                   rd_sm_data,
  input  logic [1:0]                     rd_sm_fill_l2_way,
  input  logic [1:0]                     rd_hit_l2_way,
  input  logic                           rd_cache_hit,
  input  logic [511:0]                   rd_cache_mem_result,
  input  logic [L2_TAG_WIDTH-1:0]        rd_replace_l2_tag,
  input  logic                           rd_replace_is_dirty,
  input  logic                           rd_store_sync_success,
  output logic                           wr_pci_valid,
  output logic [1:0]                     wr_pci_unit,
  output logic [1:0]                     wr_pci_strand,
  output logic [2:0]                     wr_pci_op,
  output logic [1:0]                     wr_pci_way,
  output logic [25:0]                    wr_pci_address,
  output logic [511:0]                   wr_data,
  output logic                           wr_store_sync_success,
  output logic                           wr_update_l2_data,
  output logic [L2_CACHE_ADDR_WIDTH-1:0] wr_cache_write_index,
  output logic [511:0]                   wr_update_data,
  output logic                           wr_update_dirty,
  output logic                           wr_dirty_value,
  output logic                           wb_valid,
  output logic [25:0]                    wb_address,
  output logic [511:0]                   wb_data,
  input  logic                           wb_ready,
  output logic                           wr_wb_full
);
  logic [L2_SET_INDEX_WIDTH-1:0]  set;
  logic [1:0]                     way;
  logic [L2_CACHE_ADDR_WIDTH-1:0] write_index;
  logic                           bypass_hit, victim_bypass_hit;
  logic [511:0]                   source_line, merged_line, victim_line;
  logic                           store_en, do_write, wb_push, wb_pop, wb_empty;
  logic                           update_q;
  wb_entry_t                      push_entry, head_entry;

  assign set         = rd_pci_address[L2_SET_INDEX_WIDTH-1:0];
  assign way         = rd_cache_hit ? rd_hit_l2_way : rd_sm_fill_l2_way;
  assign write_index = {way, set};

  // The pending SRAM write register doubles as the bypass: the SRAM returns
  // pre-write data for a read that collides with this write.
  assign bypass_hit        = update_q && (wr_cache_write_index == write_index);
  assign victim_bypass_hit = update_q && (wr_cache_write_index == {rd_sm_fill_l2_way, set});

  assign source_line = rd_has_sm_data ? rd_sm_data
                     : bypass_hit     ? wr_update_data
                     :                  rd_cache_mem_result;
  assign victim_line = victim_bypass_hit ? wr_update_data : rd_cache_mem_result;
  assign merged_line = merge_line(source_line, rd_pci_data, rd_pci_mask);

  assign store_en = rd_pci_valid && (rd_pci_op == PCI_STORE
                    || (rd_pci_op == PCI_STORE_SYNC && rd_store_sync_success));
  assign do_write = rd_pci_valid && (rd_has_sm_data || (store_en && rd_cache_hit));

  assign wb_push            = !stall_pipeline && rd_pci_valid && rd_has_sm_data && rd_replace_is_dirty;
  assign push_entry.address = {rd_replace_l2_tag, set};
  assign push_entry.data    = victim_line;
  assign wb_valid           = !wb_empty;
  assign wb_pop             = wb_valid && wb_ready;
  assign wb_address         = head_entry.address;
  assign wb_data            = head_entry.data;

  // a held write is re-issued only once the stall releases
  assign wr_update_l2_data = update_q && !stall_pipeline;
  assign wr_update_dirty   = update_q && !stall_pipeline;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pci_valid          <= 1'b0;
      wr_pci_unit           <= '0;
      wr_pci_strand         <= '0;
      wr_pci_op             <= '0;
      wr_pci_way            <= '0;
      wr_pci_address        <= '0;
      wr_data               <= '0;
      wr_store_sync_success <= 1'b0;
      update_q              <= 1'b0;
      wr_cache_write_index  <= '0;
      wr_update_data        <= '0;
      wr_dirty_value        <= 1'b0;
    end else if (!stall_pipeline) begin
      wr_pci_valid          <= rd_pci_valid;
      wr_pci_unit           <= rd_pci_unit;
      wr_pci_strand         <= rd_pci_strand;
      wr_pci_op             <= rd_pci_op;
      wr_pci_way            <= rd_pci_way;
      wr_pci_address        <= rd_pci_address;
      wr_data               <= merged_line;
      wr_store_sync_success <= rd_store_sync_success;
      update_q              <= do_write;
      wr_cache_write_index  <= write_index;
      wr_update_data        <= merged_line;
      wr_dirty_value        <= store_en;
    end
  end

  l2_writeback_fifo #(.DEPTH(WB_DEPTH), .W(WB_ENTRY_W)) u_wb_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (wb_push),
    .push_data   (push_entry),
    .pop         (wb_pop),
    .head_data   (head_entry),
    .empty       (wb_empty),
    .almost_full (wr_wb_full)
  );
endmodule
